// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: stall/flush/forward generation with a run/memwait FSM.
// Optional PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteW,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  running,
`ifdef PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt,
`endif
  output logic                  mem_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] TO_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [WW-1:0] W_MAX   = '1;

  if (MEM_TIMEOUT < 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("pipeline_hazard_ctrl: bad parameter");
  end

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;

  logic idle, mem_stall, lw_stall, timeout;

  assign idle = rst | (state_q == IDLE);
  assign mem_stall = !idle & ((state_q == MEMWAIT) |
                     ((state_q == RUN) & MemReqM & !MemReadyM));
  assign lw_stall = (ResultSrcE == 2'b01) & (RdE != '0) &
                    ((RdE == Rs1D) | (RdE == Rs2D));
  assign timeout = (state_q == MEMWAIT) & !MemReadyM &
                   (wait_cnt_q == TO_LAST);

  assign running = !rst & (state_q != IDLE);
  assign mem_err = mem_err_q;

  function automatic logic [1:0] fwd(input logic [ADDR_WIDTH-1:0] rs);
    if (RegWriteM && RdM != '0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != '0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign ForwardAE = fwd(Rs1E);
  assign ForwardBE = fwd(Rs2E);

  // Overlapping conditions resolve top-down, so priority not unique.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    priority case (1'b1)
      idle: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      mem_stall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end
      PCSrcE: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      lw_stall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q;
    case (state_q)
      IDLE: if (trigger) state_d = RUN;
      RUN: if (MemReqM && !MemReadyM) state_d = MEMWAIT;
      MEMWAIT: begin
        if (MemReadyM) begin
          state_d = RUN;
        end else if (timeout) begin
          state_d   = IDLE;
          mem_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    if (state_d == MEMWAIT && state_q == MEMWAIT)
      wait_cnt_d = (wait_cnt_q == W_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q +
                       CNT_WIDTH'(StallF & (state_q != IDLE));
  assign flush_cnt_d = flush_cnt_q + CNT_WIDTH'(FlushD);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl.
// Compares every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst, trigger, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic running, mem_err;
`ifdef PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .ADDR_WIDTH(AW), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW),
    .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .running(running),
`ifdef PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_err(mem_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=run 2=waiting on memory
  int m_mode, m_waited;
  bit m_err;
  int unsigned m_stalls, m_flushes;
  logic [5:0] e_vec;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic calc_exp();
    bit lw;
    lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (m_mode == 0) e_vec = 6'b110001;
    else if (m_mode == 2 || (MemReqM && !MemReadyM)) e_vec = 6'b111100;
    else if (PCSrcE) e_vec = 6'b000011;
    else if (lw) e_vec = 6'b110001;
    else e_vec = 6'b000000;
  endtask

  task automatic model_update();
    if (e_vec[5] && m_mode != 0) m_stalls++;
    if (e_vec[1]) m_flushes++;
    case (m_mode)
      0: if (trigger) m_mode = 1;
      1: if (MemReqM && !MemReadyM) begin
        m_mode = 2;
        m_waited = 0;
      end
      default: begin
        if (MemReadyM) m_mode = 1;
        else if (m_waited + 1 == TO) begin
          m_mode = 0;
          m_err = 1;
        end else m_waited++;
      end
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_waited = 0;
    m_err = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic clear_in();
    trigger = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 1; ResultSrcE = 2'b00;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    calc_exp();
    chk({tag, ".haz"},
        {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE},
        {26'd0, e_vec});
    chk({tag, ".fa"}, {30'd0, ForwardAE}, {30'd0, ref_fwd(Rs1E)});
    chk({tag, ".fb"}, {30'd0, ForwardBE}, {30'd0, ref_fwd(Rs2E)});
    chk({tag, ".run"}, {31'd0, running}, {31'd0, m_mode != 0});
    chk({tag, ".err"}, {31'd0, mem_err}, {31'd0, m_err});
`ifdef PERF_CNT_EN
    chk({tag, ".scnt"}, stall_cnt, m_stalls);
    chk({tag, ".fcnt"}, flush_cnt, m_flushes);
`endif
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    #2;
    chk("rst.haz", {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE},
        32'h31);
    chk("rst.run", {31'd0, running}, 32'd0);
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;

    for (int i = 0; i < 5; i++) step("idle");
    trigger = 1;
    step("trig");
    trigger = 0;
    step("run0");

    ResultSrcE = 2'b01; RdE = 5; Rs2D = 5;
    step("lw");
    RdE = 0;
    step("lw0");
    ResultSrcE = 2'b00;

    RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 3;
    step("fwdM");
    RegWriteM = 0;
    step("fwdW");
    RegWriteM = 1; RdM = 0; RdW = 0;
    step("fwd0");
    clear_in();

    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    step("br_lw");
    clear_in();

    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) step("mwait");
    MemReadyM = 1;
    step("mrel");
    MemReqM = 0;
    step("mrun");

    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < TO + 3; i++) step("tmo");
    clear_in();
    trigger = 1;
    step("restart");
    trigger = 0;
    step("rs_run");

    for (int i = 0; i < 400; i++) begin
      trigger    = ($urandom_range(0, 15) == 0);
      Rs1D       = AW'($urandom_range(0, 7));
      Rs2D       = AW'($urandom_range(0, 7));
      Rs1E       = AW'($urandom_range(0, 7));
      Rs2E       = AW'($urandom_range(0, 7));
      RdE        = AW'($urandom_range(0, 7));
      RdM        = AW'($urandom_range(0, 7));
      RdW        = AW'($urandom_range(0, 7));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = ($urandom_range(0, 3) == 0);
      MemReadyM  = ($urandom_range(0, 4) != 0);
      if (i == 200) do_reset();
      step("rnd");
    end

    clear_in();
    do_reset();
    step("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
